hazard_scoreboard: RTL

//  Parametrised RAW/control hazard unit for the 5-stage MIPS pipeline, sitting beside the IF/ID register.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_decode.sv | 83 ++++++++
 rtl/hazard_scoreboard.sv | 130 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: MIPS opcode/funct constants,
// scoreboard entry layout and FSM state encoding.
package hazard_pkg;

  localparam logic [5:0] RTYPE = 6'h00;
  localparam logic [5:0] JUMP  = 6'h02;
  localparam logic [5:0] JAL   = 6'h03;
  localparam logic [5:0] BEQ   = 6'h04;
  localparam logic [5:0] BNE   = 6'h05;
  localparam logic [5:0] ADDI  = 6'h08;
  localparam logic [5:0] XORI  = 6'h0E;
  localparam logic [5:0] LW    = 6'h23;
  localparam logic [5:0] SW    = 6'h2B;
  localparam logic [5:0] JR    = 6'h08;  // funct field under RTYPE

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } sb_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_decode.sv
// Combinational register-usage decode of one MIPS instruction.
// Register 0 is never reported as a valid source or destination.
module hazard_decode
  import hazard_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  src_a,
  output logic        src_a_v,
  output logic [4:0]  src_b,
  output logic        src_b_v,
  output logic [4:0]  dest,
  output logic        dest_v,
  output logic        is_load,
  output logic        is_ctrl
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign funct = instr[5:0];

  always_comb begin
    src_a   = rs;
    src_b   = rt;
    dest    = 5'd0;
    src_a_v = 1'b0;
    src_b_v = 1'b0;
    dest_v  = 1'b0;
    is_load = 1'b0;
    is_ctrl = 1'b0;
    case (op)
      RTYPE: begin
        if (instr != 32'h0) begin
          src_a_v = 1'b1;
          if (funct != JR) begin
            src_b_v = 1'b1;
            dest    = rd;
            dest_v  = 1'b1;
          end
        end
      end
      ADDI, XORI: begin
        src_a_v = 1'b1;
        dest    = rt;
        dest_v  = 1'b1;
      end
      LW: begin
        src_a_v = 1'b1;
        dest    = rt;
        dest_v  = 1'b1;
        is_load = 1'b1;
      end
      SW: begin
        src_a_v = 1'b1;
        src_b_v = 1'b1;
      end
      BEQ, BNE: begin
        src_a_v = 1'b1;
        src_b_v = 1'b1;
        is_ctrl = 1'b1;
      end
      JAL: begin
        dest    = 5'd31;
        dest_v  = 1'b1;
        is_ctrl = 1'b1;
      end
      JUMP: is_ctrl = 1'b1;
      default: ;
    endcase
    // $0 is hard-wired, so it can never carry a dependency
    if (src_a == 5'd0) src_a_v = 1'b0;
    if (src_b == 5'd0) src_b_v = 1'b0;
    if (dest  == 5'd0) dest_v  = 1'b0;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW/control hazard unit beside IF/ID; build with FORWARDING_EN defined to
// stall only on load-use, otherwise any in-flight producer stalls decode.
//   state | meaning
//   RUN   | issue from IF/ID unless a register hazard is pending
//   DRAIN | insert bub_cnt bubbles after a taken-path control op
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int WINDOW       = 3,
  parameter int CTRL_BUBBLES = 2,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hold,
  input  logic [31:0]            id_instr,
  output logic                   regIF_en,
  output logic                   regID_en,
  output logic                   nopMux,
  output logic                   pcEnable,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic [4:0] src_a;
  logic       src_a_v;
  logic [4:0] src_b;
  logic       src_b_v;
  logic [4:0] dest;
  logic       dest_v;
  logic       is_load;
  logic       is_ctrl;

  hazard_decode u_decode (
    .instr   (id_instr),
    .src_a   (src_a),
    .src_a_v (src_a_v),
    .src_b   (src_b),
    .src_b_v (src_b_v),
    .dest    (dest),
    .dest_v  (dest_v),
    .is_load (is_load),
    .is_ctrl (is_ctrl)
  );

  sb_entry_t [WINDOW-1:0] sb_q;
  sb_entry_t              new_entry;
  state_t                 state_q, state_d;
  logic [1:0]             bub_q, bub_d;
  logic                   hazard;
  logic                   issue;
  logic                   lint_unused;

  // Entries past the compare range are only shifted, never inspected
  assign lint_unused = ^sb_q;

  always_comb begin
    hazard = 1'b0;
`ifdef FORWARDING_EN
    if (sb_q[0].valid && sb_q[0].is_load &&
        ((src_a_v && sb_q[0].dest == src_a) || (src_b_v && sb_q[0].dest == src_b)))
      hazard = 1'b1;
`else
    for (int k = 0; k < WINDOW; k++) begin
      if (sb_q[k].valid &&
          ((src_a_v && sb_q[k].dest == src_a) || (src_b_v && sb_q[k].dest == src_b)))
        hazard = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    bub_d    = bub_q;
    issue    = 1'b0;
    regIF_en = 1'b1;
    regID_en = 1'b1;
    pcEnable = 1'b1;
    nopMux   = 1'b0;
    if (reset) begin
      state_d = RUN;
    end else if (hold) begin
      regIF_en = 1'b0;
      regID_en = 1'b0;
      pcEnable = 1'b0;
    end else if (state_q == DRAIN) begin
      regIF_en = 1'b0;
      regID_en = 1'b0;
      pcEnable = 1'b0;
      nopMux   = 1'b1;
      bub_d    = (bub_q == 2'd0) ? 2'd0 : bub_q - 2'd1;
      if (bub_q <= 2'd1) state_d = RUN;
    end else if (hazard) begin
      regIF_en = 1'b0;
      regID_en = 1'b0;
      pcEnable = 1'b0;
      nopMux   = 1'b1;
    end else begin
      issue = 1'b1;
      if (is_ctrl && CTRL_BUBBLES != 0) begin
        state_d = DRAIN;
        bub_d   = 2'(CTRL_BUBBLES);
      end
    end
  end

  always_comb begin
    new_entry = '0;
    if (issue) begin
      new_entry.valid   = dest_v;
      new_entry.dest    = dest;
      new_entry.is_load = is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      bub_q     <= 2'd0;
      stall_cnt <= '0;
      sb_q      <= '0;
    end else if (!hold) begin
      state_q <= state_d;
      bub_q   <= bub_d;
      if (nopMux && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      for (int k = WINDOW - 1; k > 0; k--) sb_q[k] <= sb_q[k-1];
      sb_q[0] <= new_entry;
    end
  end

endmodule
